pc_call_stack: RTL

//  Parametrised program counter for the Hack CPU fetch stage. It extends plain

---
 rtl/hack_pkg.sv | 28 ++
 rtl/pc_call_stack_if.sv | 37 +++
 rtl/pc_call_stack_ret_stack.sv | 54 +++++
 rtl/pc_call_stack.sv | 91 +++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared Hack CPU fetch definitions: address width, return-stack depth and op priority encoding.
// Used by the PC and the CPU decoder; no logic state lives here.
package hack_pkg;

  localparam int HACK_ADDR_W      = 15;
  localparam int HACK_STACK_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_RET  = 3'd2,
    OP_CALL = 3'd3,
    OP_LOAD = 3'd4
  } op_t;

  // Fixed priority load > call > ret > inc > hold; losers are simply discarded.
  function automatic op_t op_select(input logic load, input logic call,
                                    input logic ret, input logic inc);
    op_t op;
    if (load)      op = OP_LOAD;
    else if (call) op = OP_CALL;
    else if (ret)  op = OP_RET;
    else if (inc)  op = OP_INC;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc_call_stack_if.sv
// Control/status bundle between the CPU jump/decode logic (master) and the PC (slave).
// Pure wiring; timing is set entirely by the PC's registers.
interface pc_call_stack_if
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_ADDR_W,
  parameter int DEPTH = HACK_STACK_DEPTH
);

  localparam int DW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in;
  logic             load;
  logic             call;
  logic             ret;
  logic             inc;
  logic             stall;
  logic             clr_err;

  logic [WIDTH-1:0] out;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output in, load, call, ret, inc, stall, clr_err,
    input  out, depth, empty, full, overflow, underflow
  );

  modport slave (
    input  in, load, call, ret, inc, stall, clr_err,
    output out, depth, empty, full, overflow, underflow
  );

endinterface

// File: rtl/pc_call_stack_ret_stack.sv
// Circular LIFO of return addresses; push/pop take effect at the clock edge, top is registered data.
// No backpressure: a push when full is dropped or, with WRAP, overwrites the oldest entry.
module ret_stack
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_ADDR_W,
  parameter int DEPTH = HACK_STACK_DEPTH,
  parameter bit WRAP  = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [DW-1:0]    cnt;
  logic             wr_en;

  assign full  = (cnt == DW'(DEPTH));
  assign empty = (cnt == '0);
  assign depth = cnt;
  assign top   = mem[wp - PW'(1)];

  // When full, wp points at the oldest slot, so a wrapping push overwrites it naturally.
  assign wr_en = push && (!full || WRAP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp  <= '0;
      cnt <= '0;
    end else if (wr_en) begin
      wp <= wp + PW'(1);
      if (!full) cnt <= cnt + DW'(1);
    end else if (pop && !empty) begin
      wp  <= wp - PW'(1);
      cnt <= cnt - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en) mem[wp] <= wr_data;
  end

endmodule

// File: rtl/pc_call_stack.sv
// Hack fetch PC with load/call/ret/inc, return stack and sticky overflow/underflow flags.
// One-cycle latency to out/depth; no backpressure, stall freezes every register.
module pc_call_stack
  import hack_pkg::*;
#(
  parameter int               WIDTH      = HACK_ADDR_W,
  parameter int               DEPTH      = HACK_STACK_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0,
  parameter bit               WRAP_STACK = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  pc_call_stack_if.slave      bus
);

  localparam int DW = $clog2(DEPTH) + 1;

  op_t              op;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] stk_top;
  logic [DW-1:0]    stk_depth;
  logic             stk_full;
  logic             stk_empty;
  logic             push;
  logic             pop;
  logic             set_ovf;
  logic             set_udf;
  logic             ovf_q;
  logic             udf_q;

  always_comb begin
    op      = OP_HOLD;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    pc_inc  = pc_q + WIDTH'(1);
    if (!bus.stall) op = op_select(bus.load, bus.call, bus.ret, bus.inc);
    if (op == OP_CALL) begin
      push    = 1'b1;
      set_ovf = stk_full;
    end
    if (op == OP_RET) begin
      pop     = !stk_empty;
      set_udf = stk_empty;
    end
  end

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .WRAP  (WRAP_STACK)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (pc_inc),
    .top     (stk_top),
    .depth   (stk_depth),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (!bus.stall) begin
      case (op)
        OP_LOAD, OP_CALL: pc_q <= bus.in;
        OP_RET:           if (!stk_empty) pc_q <= stk_top;
        OP_INC:           pc_q <= pc_inc;
        default:          pc_q <= pc_q;
      endcase
      // A new error in the same cycle as clr_err keeps its flag set.
      ovf_q <= set_ovf | (ovf_q & ~bus.clr_err);
      udf_q <= set_udf | (udf_q & ~bus.clr_err);
    end
  end

  assign bus.out       = pc_q;
  assign bus.depth     = stk_depth;
  assign bus.empty     = stk_empty;
  assign bus.full      = stk_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;

endmodule
